// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: bus widths and field layout shared by the memory-access stage.
// Provides EXE_TO_MEM_BUS_WD / MEM_TO_WB_BUS_WD and the packed execute-to-memory payload.
package mem_stage_pkg;

    localparam int EXE_TO_MEM_BUS_WD = 160;
    localparam int MEM_TO_WB_BUS_WD  = 152;

    // Field order is MSB first, matching exe_to_mem_bus bit positions.
    typedef struct packed {
        logic        csr_re;
        logic [31:0] csr_wvalue;
        logic [13:0] csr_num;
        logic        csr_we;
        logic [31:0] csr_wmask;
        logic        syscall;
        logic        ertn;
        logic        ld_b;
        logic        ld_bu;
        logic        ld_h;
        logic        ld_hu;
        logic        ld_w;
        logic        signed_option;
        logic        lu12i_w;
        logic        load_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } exe_to_mem_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: selects and extends the addressed byte/half/word of load data.
// Ports: rdata (32b word), a (byte offset), ld_b/ld_bu/ld_h/ld_hu/ld_w (load kind), result (32b).
module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic        ld_b,
    input  logic        ld_bu,
    input  logic        ld_h,
    input  logic        ld_hu,
    input  logic        ld_w,
    output logic [31:0] result
);

    logic [31:0] shifted;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Halves use only a[1]; a[0] is ignored.
    always_comb begin
        shifted  = rdata >> {a, 3'b000};
        byte_sel = shifted[7:0];
        half_sel = a[1] ? rdata[31:16] : rdata[15:0];
        result   = ld_b  ? {{24{byte_sel[7]}}, byte_sel} :
                   ld_bu ? {24'b0, byte_sel} :
                   ld_h  ? {{16{half_sel[15]}}, half_sel} :
                   ld_hu ? {16'b0, half_sel} :
                   ld_w  ? rdata : 32'b0;
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage; registers execute payload, aligns load data,
// holds SRAM read data across write-back stalls, and forwards results to decode.
// Ports: clk/resetn; exe_to_mem_valid/bus in, mem_allowin out; data_sram_rdata in;
// wb_allowin in, mem_to_wb_valid/bus out; gr_we_mem, dest_mem, forward_data_mem,
// mem_csr_re, mem_ex out; wb_ex in (flush).
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         exe_to_mem_valid,
    input  logic [EXE_TO_MEM_BUS_WD-1:0] exe_to_mem_bus,
    output logic                         mem_allowin,
    input  logic [31:0]                  data_sram_rdata,
    input  logic                         wb_allowin,
    output logic                         mem_to_wb_valid,
    output logic [MEM_TO_WB_BUS_WD-1:0]  mem_to_wb_bus,
    output logic                         gr_we_mem,
    output logic [4:0]                   dest_mem,
    output logic [31:0]                  forward_data_mem,
    output logic                         mem_csr_re,
    output logic                         mem_ex,
    input  logic                         wb_ex
);

    exe_to_mem_t r;
    logic        mem_valid;
    logic        mem_ready_go;
    logic        first;
    logic        buf_valid;
    logic [31:0] rdata_buf;
    logic [31:0] rdata;
    logic [31:0] load_result;
    logic [31:0] final_result;
    logic        accept;
    logic        taken;
    logic        unused;

    assign mem_ready_go    = 1'b1;
    assign mem_allowin     = !mem_valid | (mem_ready_go & wb_allowin);
    assign mem_to_wb_valid = mem_valid & mem_ready_go & !wb_ex;
    assign accept          = exe_to_mem_valid & mem_allowin & !wb_ex;
    assign taken           = mem_to_wb_valid & wb_allowin;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid <= 1'b0;
            r         <= '0;
            first     <= 1'b0;
            buf_valid <= 1'b0;
            rdata_buf <= 32'b0;
        end else begin
            mem_valid <= wb_ex ? 1'b0 : mem_allowin ? exe_to_mem_valid : mem_valid;
            if (exe_to_mem_valid & mem_allowin)
                r <= exe_to_mem_bus;
            first <= accept;
            // SRAM data is only valid in the first resident cycle; capture it if we will stall.
            if (first & !taken)
                rdata_buf <= data_sram_rdata;
            if (wb_ex | accept)
                buf_valid <= 1'b0;
            else if (first & !taken)
                buf_valid <= 1'b1;
        end
    end

    assign rdata = buf_valid ? rdata_buf : data_sram_rdata;

    load_align u_load_align (
        .rdata  (rdata),
        .a      (r.alu_result[1:0]),
        .ld_b   (r.ld_b),
        .ld_bu  (r.ld_bu),
        .ld_h   (r.ld_h),
        .ld_hu  (r.ld_hu),
        .ld_w   (r.ld_w),
        .result (load_result)
    );

    assign final_result = r.load_op ? load_result : r.alu_result;

    assign mem_to_wb_bus = {r.csr_re, r.csr_wvalue, r.csr_num, r.csr_we, r.csr_wmask,
                            r.syscall, r.ertn, r.gr_we, r.dest, final_result, r.pc};

    assign gr_we_mem        = r.gr_we & mem_valid;
    assign dest_mem         = mem_valid ? r.dest : 5'd0;
    assign forward_data_mem = mem_valid ? final_result : 32'd0;
    assign mem_csr_re       = r.csr_re & mem_valid;
    assign mem_ex           = r.syscall & mem_valid;

    assign unused = ^{r.signed_option, r.lu12i_w};

endmodule
